// File: rtl/pong_pkg.sv
// Shared Pong definitions: bounce codes, screen geometry and referee state encoding.
package pong_pkg;

   localparam int unsigned SCREEN_X = 640;
   localparam int unsigned SCREEN_Y = 480;

   localparam logic [1:0] BOUNCE_NONE   = 2'b00;
   localparam logic [1:0] BOUNCE_PADDLE = 2'b01;
   localparam logic [1:0] BOUNCE_WALL   = 2'b10;
   localparam logic [1:0] BOUNCE_SCORE  = 2'b11;

   typedef enum logic [1:0] {
      ST_PLAY  = 2'd0,
      ST_COOL  = 2'd1,
      ST_SERVE = 2'd2,
      ST_OVER  = 2'd3
   } ref_state_e;

endpackage

// File: rtl/rect_overlap.sv
// Combinational overlap test for two rectangles given as [x0,x1) x [y0,y1).
module rect_overlap (
   input  logic [10:0] a_x0,
   input  logic [10:0] a_y0,
   input  logic [10:0] a_x1,
   input  logic [10:0] a_y1,
   input  logic [10:0] b_x0,
   input  logic [10:0] b_y0,
   input  logic [10:0] b_x1,
   input  logic [10:0] b_y1,
   output logic        overlap_c
);

   assign overlap_c = (a_x0 < b_x1) && (a_x1 > b_x0) &&
                      (a_y0 < b_y1) && (a_y1 > b_y0);

endmodule

// File: rtl/pong_referee.sv
// Pong referee: collision/score detection, cooldown and serve timing, score keeping.
module pong_referee #(
   parameter int unsigned SCREEN_X    = pong_pkg::SCREEN_X,
   parameter int unsigned SCREEN_Y    = pong_pkg::SCREEN_Y,
   parameter int unsigned PADDLE_W    = 10,
   parameter int unsigned PADDLE_H    = 80,
   parameter int unsigned PADDLE_L_X  = 20,
   parameter int unsigned PADDLE_R_X  = 610,
   parameter int unsigned COOLDOWN    = 4,
   parameter int unsigned SERVE_DELAY = 60,
   parameter int unsigned WIN_SCORE   = 9
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick,
   input  logic [9:0] ball_x,
   input  logic [9:0] ball_y,
   input  logic [7:0] ball_w,
   input  logic [7:0] ball_h,
   input  logic [9:0] paddle_l_y,
   input  logic [9:0] paddle_r_y,
   output logic [1:0] bounce,
   output logic [3:0] score_l,
   output logic [3:0] score_r,
   output logic       game_over,
   output logic       winner
);

   localparam logic [9:0] WRAP_LIMIT = 10'd960;

   // Edge terms at 11 bits so the far edge cannot wrap
   logic [10:0] bx0_c, by0_c, bx2_c, by2_c;
   logic        ux_c, uy_c;
   logic        miss_l_c, miss_r_c, hit_l_c, hit_r_c, hit_pad_c, hit_wall_c;

   assign bx0_c = 11'(ball_x);
   assign by0_c = 11'(ball_y);
   assign bx2_c = 11'(ball_x) + 11'(ball_w);
   assign by2_c = 11'(ball_y) + 11'(ball_h);
   assign ux_c  = (ball_x >= WRAP_LIMIT);
   assign uy_c  = (ball_y >= WRAP_LIMIT);

   assign miss_l_c   = (ball_x == 10'd0) || ux_c;
   assign miss_r_c   = (bx2_c >= 11'(SCREEN_X)) && !ux_c;
   assign hit_wall_c = (ball_y == 10'd0) || uy_c || (by2_c >= 11'(SCREEN_Y));
   assign hit_pad_c  = hit_l_c || hit_r_c;

   rect_overlap u_hit_l (
      .a_x0      (bx0_c),
      .a_y0      (by0_c),
      .a_x1      (bx2_c),
      .a_y1      (by2_c),
      .b_x0      (11'(PADDLE_L_X)),
      .b_y0      (11'(paddle_l_y)),
      .b_x1      (11'(PADDLE_L_X + PADDLE_W)),
      .b_y1      (11'(paddle_l_y) + 11'(PADDLE_H)),
      .overlap_c (hit_l_c)
   );

   rect_overlap u_hit_r (
      .a_x0      (bx0_c),
      .a_y0      (by0_c),
      .a_x1      (bx2_c),
      .a_y1      (by2_c),
      .b_x0      (11'(PADDLE_R_X)),
      .b_y0      (11'(paddle_r_y)),
      .b_x1      (11'(PADDLE_R_X + PADDLE_W)),
      .b_y1      (11'(paddle_r_y) + 11'(PADDLE_H)),
      .overlap_c (hit_r_c)
   );

   pong_pkg::ref_state_e state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] bounce_d;
   logic [3:0] score_l_d, score_r_d;
   logic       game_over_d, winner_d;
   logic       score_evt_c;

   // Misses are live in both PLAY and COOL; scoring overrides the cooldown
   assign score_evt_c = tick && (miss_l_c || miss_r_c) &&
                        ((state_q == pong_pkg::ST_PLAY) || (state_q == pong_pkg::ST_COOL));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bounce_d    = pong_pkg::BOUNCE_NONE;
      score_l_d   = score_l;
      score_r_d   = score_r;
      game_over_d = game_over;
      winner_d    = winner;

      if (score_evt_c) begin
         bounce_d = pong_pkg::BOUNCE_SCORE;
         state_d  = pong_pkg::ST_SERVE;
         cnt_d    = 8'(SERVE_DELAY);
         if (miss_l_c) begin
            score_r_d = score_r + 4'd1;
            if (score_r_d == 4'(WIN_SCORE)) begin
               state_d     = pong_pkg::ST_OVER;
               game_over_d = 1'b1;
               winner_d    = 1'b1;
            end
         end else begin
            score_l_d = score_l + 4'd1;
            if (score_l_d == 4'(WIN_SCORE)) begin
               state_d     = pong_pkg::ST_OVER;
               game_over_d = 1'b1;
               winner_d    = 1'b0;
            end
         end
      end else if (tick) begin
         case (state_q)
            pong_pkg::ST_PLAY: begin
               if (hit_pad_c) begin
                  bounce_d = pong_pkg::BOUNCE_PADDLE;
                  state_d  = pong_pkg::ST_COOL;
                  cnt_d    = 8'(COOLDOWN);
               end else if (hit_wall_c) begin
                  bounce_d = pong_pkg::BOUNCE_WALL;
                  state_d  = pong_pkg::ST_COOL;
                  cnt_d    = 8'(COOLDOWN);
               end
            end
            pong_pkg::ST_COOL, pong_pkg::ST_SERVE: begin
               cnt_d = cnt_q - 8'd1;
               if (cnt_q <= 8'd1) begin
                  cnt_d   = 8'd0;
                  state_d = pong_pkg::ST_PLAY;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= pong_pkg::ST_SERVE;
         cnt_q     <= 8'(SERVE_DELAY);
         bounce    <= pong_pkg::BOUNCE_NONE;
         score_l   <= 4'd0;
         score_r   <= 4'd0;
         game_over <= 1'b0;
         winner    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bounce    <= bounce_d;
         score_l   <= score_l_d;
         score_r   <= score_r_d;
         game_over <= game_over_d;
         winner    <= winner_d;
      end
   end

endmodule
